taylor_coef_seq: RTL
====================

Name: taylor_coef_seq

Overview:
Parametrised reciprocal-coefficient sequencer for the Taylor-series exp/cosh datapath. It replaces the fixed 16-entry 1/n lookup with an elaboration-time table of depth MAX_N and width W. It streams the Horner-order coefficients for a requested term count over a valid/ready interface. Mode 0 produces the exp series; mode 1 produces the cosh series in (2k, 2k-1) pairs.

Parameters:
W, 16, coefficient width; UQ0.W fraction.
MAX_N, 16, largest reciprocal index held in the table; must be even and at least 2.
NW, $clog2(MAX_N+1), width of term count and index (derived).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request a sequence; accepted only while busy=0
mode  in  1  0=exp, 1=cosh; sampled with start
terms  in  NW  exp: number of terms; cosh: number of pairs; sampled with start
abort  in  1  cancel the running sequence
busy  out  1  sequence in progress
out_valid  out  1  coefficient beat valid
out_ready  in  1  downstream accepts beat
coef  out  W  reciprocal 1/n
coef_n  out  NW  index n of current coef
pair_hi  out  1  cosh only: beat is the 1/(2k) half of a pair
last  out  1  final beat (n=1)
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Table entry n (1..MAX_N) = floor(2^W / n). Entry 1 saturates to 2^W-1, so for W=16: 1→0xFFFF, 3→0x5555, 6→0x2AAA. The table is built at elaboration with no runtime divider. Index 0 is never emitted.
- Reset: busy, out_valid, last, pair_hi and done are 0; coef and coef_n are 0; FSM is in IDLE.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches mode and terms.
  - Clamping: exp clamps terms to MAX_N; cosh clamps terms to MAX_N/2.
  - Effective count 0 goes to FIN; no beats are emitted.
  - Otherwise go to RUN. The first beat is presented the cycle after start, with busy=1.
- RUN, index sequence: n starts at top = terms (exp) or 2·terms (cosh) and decrements by 1 to 1.
- RUN, beat flags:
  - pair_hi=1 when mode=1 and n is even; otherwise 0.
  - last=1 when n=1.
- RUN, handshake:
  - Beat transfers when out_valid and out_ready are both 1; the next beat appears the following cycle.
  - While out_ready=0, coef, coef_n, pair_hi and last hold stable and out_valid stays 1.
  - Transfer of the last beat goes to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored while in FIN.
- start during RUN is ignored and has no effect on the current stream.
- abort=1 in RUN or FIN goes to IDLE next cycle: out_valid=0, busy=0, no done pulse. abort has priority over a simultaneous handshake. abort in IDLE is a no-op, and abort together with start in IDLE drops the start.
- rst mid-operation behaves like abort, and all outputs return to their reset values.
- Throughput: one beat per cycle with out_ready held high.
- Latency: first beat 1 cycle after start; done 1 cycle after the last handshake.

Decomposition:
- Shared package: mode encoding (MODE_EXP=0, MODE_COSH=1), FSM state typedef, and the reciprocal-table generator function recip(n, W).
- One sub-module, recip_rom: parametrised W/MAX_N combinational ROM filled by recip(). The sequencer registers its output into coef.

Test Plan:
- W=16, exp, terms=4, out_ready=1: start at cycle 0 → cycles 1..4 emit coef 0x4000/0x5555/0x8000/0xFFFF with coef_n 4/3/2/1; last=1 only at cycle 4; done=1 at cycle 5, busy=0 at cycle 5.
- cosh, terms=2: beats n=4,3,2,1 → coef 0x4000,0x5555,0x8000,0xFFFF with pair_hi 1,0,1,0; last on n=1; done one cycle later.
- exp terms=3, out_ready low for 3 cycles while the n=2 beat is presented → coef holds 0x8000 and coef_n=2 stable; the sequence resumes on ready and still completes with 3 beats total.
- terms=0 → no out_valid, done pulses the cycle after start. exp terms=20 (NW=5) → clamps to 16, first coef 0x1000. cosh terms=9 → clamps to 8 pairs, first beat n=16.
- start pulsed mid-stream is ignored, giving the same beat sequence as without it. abort at the n=2 beat → out_valid=0 the next cycle and no done. rst mid-stream → all outputs 0 the next cycle, and a new start then runs normally.
- W=24, MAX_N=32: exp terms=3 → 0x555555 (n=3), 0x800000, 0xFFFFFF. exp terms=32 → first coef 0x080000.

Source files
------------

// File: rtl/taylor_coef_seq_pkg.sv
// Shared mode encoding, FSM state type and the elaboration-time reciprocal
// generator used to fill the coefficient ROM.
package taylor_coef_seq_pkg;

    localparam logic MODE_EXP  = 1'b0;
    localparam logic MODE_COSH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    // floor(2^w / n) as UQ0.w; n=1 would need w+1 bits so it saturates to all ones.
    function automatic logic [63:0] recip(input int n, input int w);
        logic [63:0] full;
        full = 64'd1 << w;
        if (n <= 0) return 64'd0;
        if (n == 1) return full - 64'd1;
        return full / 64'(n);
    endfunction

endpackage

// File: rtl/taylor_coef_seq_recip_rom.sv
// Combinational 1/n ROM; every entry is a constant computed at elaboration.
module recip_rom #(
    parameter int W     = 16,
    parameter int MAX_N = 16,
    parameter int NW    = $clog2(MAX_N + 1)
) (
    input  logic [NW-1:0] idx,
    output logic [W-1:0]  data
);
    import taylor_coef_seq_pkg::*;

    // Full power-of-two depth so any index decodes; entries past MAX_N read zero.
    localparam int DEPTH = 1 << NW;

    logic [W-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        localparam logic [63:0] VAL = (g >= 1 && g <= MAX_N) ? recip(g, W) : 64'd0;
        assign rom[g] = VAL[W-1:0];
    end

    assign data = rom[idx];

endmodule

// File: rtl/taylor_coef_seq.sv
// Streams Horner-order reciprocal coefficients for the exp/cosh Taylor datapath
// over a valid/ready interface, one beat per cycle when the sink is ready.
module taylor_coef_seq #(
    parameter int W     = 16,
    parameter int MAX_N = 16,
    parameter int NW    = $clog2(MAX_N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [NW-1:0] terms,
    input  logic          abort,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  coef,
    output logic [NW-1:0] coef_n,
    output logic          pair_hi,
    output logic          last,
    output logic          done
);
    import taylor_coef_seq_pkg::*;

    if (MAX_N < 2 || (MAX_N % 2) != 0) begin : g_bad_max_n
        $error("taylor_coef_seq: MAX_N must be even and at least 2");
    end

    localparam logic [NW-1:0] EXP_CAP  = NW'(MAX_N);
    localparam logic [NW-1:0] PAIR_CAP = NW'(MAX_N / 2);
    localparam logic [NW-1:0] ONE      = NW'(1);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [NW-1:0] n_q, n_d;
    logic [W-1:0]  coef_q;
    logic [W-1:0]  rom_data;
    logic [NW-1:0] exp_cnt, pair_cnt, top_n;
    logic          accept;

    // Clamped starting index; a cosh pair count of k starts the walk at n = 2k.
    always_comb begin
        exp_cnt  = (terms > EXP_CAP) ? EXP_CAP : terms;
        pair_cnt = (terms > PAIR_CAP) ? PAIR_CAP : terms;
        top_n    = (mode == MODE_COSH) ? (pair_cnt << 1) : exp_cnt;
    end

    assign accept = (state_q == ST_IDLE) && start && !abort;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (top_n == '0) ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                if (abort)                          state_d = ST_IDLE;
                else if (out_ready && (n_q == ONE)) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Index walk: load on accept, step on transfer, hold on stall, clear otherwise.
    always_comb begin
        n_d    = '0;
        mode_d = mode_q;
        if (accept) mode_d = mode;
        if (state_d == ST_RUN) begin
            if (state_q == ST_IDLE) n_d = top_n;
            else if (out_ready)     n_d = n_q - ONE;
            else                    n_d = n_q;
        end
    end

    recip_rom #(
        .W     (W),
        .MAX_N (MAX_N),
        .NW    (NW)
    ) u_rom (
        .idx  (n_d),
        .data (rom_data)
    );

    // NOTE: reset clears every datapath register, including coef, so the
    // outputs read zero after rst exactly as they do at power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_EXP;
            n_q    <= '0;
            coef_q <= '0;
        end else begin
            mode_q <= mode_d;
            n_q    <= n_d;
            coef_q <= rom_data;
        end
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        pair_hi   = 1'b0;
        last      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                pair_hi   = (mode_q == MODE_COSH) && !n_q[0];
                last      = (n_q == ONE);
            end
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

    assign coef   = coef_q;
    assign coef_n = n_q;

endmodule
